prod_accumulator: RTL



---
 rtl/prod_accumulator_pkg.sv | 27 ++
 rtl/prod_accumulator_if.sv | 28 ++
 rtl/acc_prefix_adder.sv | 33 +++
 rtl/prod_accumulator.sv | 88 ++++++++
 4 files changed

// File: rtl/prod_accumulator_pkg.sv
// Shared types, default widths and prefix-adder cells for the product accumulator.
package prod_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_t;

   localparam int PROD_W_D = 8;
   localparam int ACC_W_D  = 16;

   function automatic int cnt_width(input int max_terms);
      return $clog2(max_terms + 1);
   endfunction

   // Grey cell: group generate only, used once the low group already reaches bit 0.
   function automatic logic grey_cell(input logic g_hi, input logic p_hi, input logic g_lo);
      return g_hi | (p_hi & g_lo);
   endfunction

   function automatic logic [1:0] black_cell(input logic g_hi, input logic p_hi,
                                             input logic g_lo, input logic p_lo);
      return {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

endpackage

// File: rtl/prod_accumulator_if.sv
// Product-in / result-out handshake bundle between the multiplier stage and its consumer.
interface prod_acc_if
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_D,
   parameter int ACC_W  = ACC_W_D,
   parameter int CNT_W  = cnt_width(16)
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/acc_prefix_adder.sv
// Kogge-Stone style prefix adder with carry-out, same grey/black cells as the multiplier's final adder.
module acc_prefix_adder
   import prod_acc_pkg::*;
#(
   parameter int ACC_W = ACC_W_D
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);
   localparam int LVL = $clog2(ACC_W);

   always_comb begin
      logic [ACC_W-1:0] gg, pp, gn, pn;
      gg = a & b;
      pp = a ^ b;
      for (int k = 0; k < LVL; k++) begin
         gn = gg;
         pn = pp;
         for (int i = 0; i < ACC_W; i++) begin
            if (i >= (1 << k) && i < (2 << k))
               gn[i] = grey_cell(gg[i], pp[i], gg[i - (1 << k)]);
            else if (i >= (2 << k))
               {gn[i], pn[i]} = black_cell(gg[i], pp[i], gg[i - (1 << k)], pp[i - (1 << k)]);
         end
         gg = gn;
         pp = pn;
      end
      sum   = (a ^ b) ^ {gg[ACC_W-2:0], 1'b0};
      carry = gg[ACC_W-1];
   end
endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a run of multiplier products into a wide sum and presents it on a held output handshake.
//   state | meaning
//   IDLE  | waiting for the first beat of a run
//   ACCUM | run in progress, adding each accepted beat
//   HOLD  | result presented, waiting for out_ready; no beats accepted
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PROD_W    = PROD_W_D,
   parameter int ACC_W     = ACC_W_D,
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = cnt_width(MAX_TERMS)
) (
   input  logic         clk,
   input  logic         rst_n,
   prod_acc_if.slave    bus
);
   localparam logic [CNT_W-1:0] TERM_LIMIT = CNT_W'(MAX_TERMS);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;

   logic             accept;
   logic [ACC_W-1:0] a_op, b_op, sum_nxt;
   logic             carry;
   logic [CNT_W-1:0] count_nxt;
   logic             ovf_nxt;
   logic             run_done;

   assign bus.in_ready = (state != HOLD) && rst_n;
   assign accept       = bus.in_valid && bus.in_ready;

   // Gating the product with accept keeps an X on an idle bus out of the datapath.
   assign a_op = (state == ACCUM) ? acc : '0;
   assign b_op = accept ? ACC_W'(bus.in_prod) : '0;

   acc_prefix_adder #(.ACC_W(ACC_W)) u_adder (
      .a     (a_op),
      .b     (b_op),
      .sum   (sum_nxt),
      .carry (carry)
   );

   assign count_nxt = (state == ACCUM) ? count + 1'b1 : CNT_W'(1);
   assign ovf_nxt   = ((state == ACCUM) && ovf) | carry;
   assign run_done  = bus.in_last || (count_nxt == TERM_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         count         <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_count <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= sum_nxt;
                  count <= count_nxt;
                  ovf   <= ovf_nxt;
                  if (run_done) begin
                     state         <= HOLD;
                     bus.out_valid <= 1'b1;
                     bus.out_sum   <= sum_nxt;
                     bus.out_count <= count_nxt;
                     bus.out_ovf   <= ovf_nxt;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
